huffman_decoder: RTL and testbench
==================================

# huffman_decoder

Consumes the Huffman tree produced by the tree-builder (eight 15-bit node entries plus the two root branches) and decodes a serial compressed bitstream back into 4-bit symbols (0–9). Sits at the receive end of the compression path. It walks the tree one bit per clock under a valid/ready handshake on both the bit input and the symbol output.

## Interface
- MAX_DEPTH, 9: maximum codeword length in bits; reaching it without hitting a leaf is an error.
- CNT_W, 16: width of the decoded-symbol counter.
- Clk_in  input  1  clock, rising edge.
- n_Rst  input  1  reset, asynchronous, active-low.
- Load_tree  input  1  single-cycle strobe; latches Tree0..Tree7, Root_left and Root_right.
- Tree0..Tree7  input  15 each  node entry {parent[14:10], left[9:5], right[4:0]}; TreeK describes node 0x0a+K.
- Root_left  input  5  root child taken on bit 0.
- Root_right  input  5  root child taken on bit 1.
- Bit_in  input  1  next code bit.
- Bit_valid  input  1  Bit_in is valid.
- Bit_ready  output  1  decoder accepts Bit_in this cycle.
- Sym_out  output  4  decoded symbol.
- Code_len  output  4  length in bits of the codeword for Sym_out.
- Sym_valid  output  1  Sym_out / Code_len valid.
- Sym_ready  input  1  downstream accepts the symbol.
- Sym_cnt  output  CNT_W  number of symbols handed off (Sym_valid && Sym_ready); wraps.
- Err  output  1  sticky decode error.

## Operation
- Reset values:
  - Outputs: Bit_ready=0, Sym_out=0, Code_len=0, Sym_valid=0, Sym_cnt=0, Err=0.
  - Internal: table and root cleared to 0, state IDLE, current node = root, depth = 0.
- Node IDs:
  - 0x00–0x09 are leaves (the symbol value).
  - 0x0a–0x11 are internal nodes, indexed by id−0x0a into the latched table.
  - Any id ≥ 0x12 is invalid.
  - The latched parent field is ignored for lookup.
- Branch rule: bit 0 takes the left/Root_left branch; bit 1 takes the right/Root_right branch.
- States:
  - IDLE: no tree loaded. Load_tree → WALK.
  - WALK: on each accepted bit, next = selected child of the current node (the root when depth = 0) and depth is incremented.
    - next is a leaf: load Sym_out=next, Code_len=depth+1, Sym_valid=1; return to root with depth=0.
    - next is internal and depth+1 < MAX_DEPTH: current = next.
    - next is invalid, or depth+1 = MAX_DEPTH without a leaf: Err=1, go to ERR.
  - ERR: Bit_ready=0. Only Load_tree exits (→ WALK, Err cleared). A pending symbol remains until consumed.
- Bit_ready = (state==WALK) && !Load_tree && (!Sym_valid || Sym_ready), combinational.
- Output register:
  - Sym_valid clears on Sym_ready unless a new leaf is reached in the same cycle, in which case it stays 1 with the new symbol.
  - Sym_cnt increments on every Sym_valid && Sym_ready.
- Load_tree in any state:
  - Latches the table, aborts any partial codeword (node = root, depth = 0) and clears Err.
  - Does not drop a pending Sym_valid.
  - Sym_cnt is not cleared.

## Timing
- Bit accepted at edge t (Bit_valid && Bit_ready). If it completes a codeword, Sym_valid=1 from t+1, so latency is 1 cycle from the last bit.
- Throughput is one bit per cycle with Sym_ready held high, so back-to-back 1-bit codewords produce one symbol per cycle.
- With Sym_valid=1 and Sym_ready=0, Bit_ready drops. Sym_out and Code_len stay stable until the handshake.
- Load_tree at edge t: the new table is used for bits accepted from edge t+1. Bit_ready is 0 during the Load_tree cycle.
- Async reset mid-codeword: all state returns to reset values immediately; IDLE until the next Load_tree.

## Test plan
- Full-tree decode:
  - Table: Tree0..7 = {0a,0,1},{0b,2,3},{0c,4,5},{0d,6,7},{0e,8,9},{0f,0a,0b},{10,0c,0d},{11,0e,0f}; Root_left=0x11, Root_right=0x10.
  - Stream 0100 000 100 111 → symbols 0,8,4,7 with Code_len 4,3,3,3; Sym_cnt=4.
- Backpressure: same stream with Sym_ready held 0 for 5 cycles after the first Sym_valid → Bit_ready=0 and Sym_out=0 stable; bits resume after the handshake, with no loss or duplication.
- Invalid child: Tree0={0a,15,1}, Root_left=0x0a, bits 0,0 → Err=1 one cycle after the second bit and Bit_ready=0; Load_tree → Err=0 and decoding resumes.
- Loop/depth limit: Tree0={0a,0a,1}, Root_left=0x0a, nine 0-bits → Err=1 after the 9th bit, no Sym_valid.
- Reload mid-codeword: full tree loaded, send bits 0,1, then Load_tree, then 000 → single symbol 8 with Code_len=3; partial bits discarded.
- Reset: assert n_Rst low mid-stream → all outputs 0 asynchronously; Bit_ready stays 0 until Load_tree.

Source files
------------

// File: rtl/huffman_decoder.sv
// Serial Huffman tree-walking decoder: one code bit per clock in, one 4-bit
// symbol out, valid/ready on both sides, sticky error on bad tree or overlong code.
module huffman_decoder #(
  parameter int unsigned MAX_DEPTH = 9,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk_in,
  input  logic             n_Rst,
  input  logic             Load_tree,
  input  logic [14:0]      Tree0,
  input  logic [14:0]      Tree1,
  input  logic [14:0]      Tree2,
  input  logic [14:0]      Tree3,
  input  logic [14:0]      Tree4,
  input  logic [14:0]      Tree5,
  input  logic [14:0]      Tree6,
  input  logic [14:0]      Tree7,
  input  logic [4:0]       Root_left,
  input  logic [4:0]       Root_right,
  input  logic             Bit_in,
  input  logic             Bit_valid,
  output logic             Bit_ready,
  output logic [3:0]       Sym_out,
  output logic [3:0]       Code_len,
  output logic             Sym_valid,
  input  logic             Sym_ready,
  output logic [CNT_W-1:0] Sym_cnt,
  output logic             Err
);

  typedef enum logic [1:0] {IDLE, WALK, ERR} state_t;

  state_t           state_q;
  logic [9:0]       table_q [8];
  logic [4:0]       root_l_q, root_r_q, node_q;
  logic [3:0]       depth_q, sym_q, len_q;
  logic             sym_valid_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0] idx;
  logic [9:0] entry;
  logic [4:0] next_node;
  logic [3:0] depth_inc;
  logic       is_leaf, is_internal, accept;

  // Parent fields are carried on the bus for the builder's benefit only.
  logic unused_parents;
  assign unused_parents = ^{Tree0[14:10], Tree1[14:10], Tree2[14:10], Tree3[14:10],
                            Tree4[14:10], Tree5[14:10], Tree6[14:10], Tree7[14:10]};

  always_comb begin
    idx       = 3'(node_q - 5'd10);
    entry     = table_q[idx];
    next_node = '0;
    if (depth_q == '0) next_node = Bit_in ? root_r_q : root_l_q;
    else               next_node = Bit_in ? entry[4:0] : entry[9:5];
    is_leaf     = (next_node < 5'd10);
    is_internal = (next_node >= 5'd10) && (next_node < 5'd18);
    depth_inc   = depth_q + 4'd1;
    Bit_ready   = (state_q == WALK) && !Load_tree && (!sym_valid_q || Sym_ready);
    accept      = Bit_valid && Bit_ready;
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < 8; i++) table_q[i] <= '0;
      root_l_q    <= '0;
      root_r_q    <= '0;
      node_q      <= '0;
      depth_q     <= '0;
      sym_q       <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (sym_valid_q && Sym_ready) begin
        sym_valid_q <= 1'b0;
        cnt_q       <= cnt_q + 1'b1;
      end
      if (Load_tree) begin
        table_q[0] <= Tree0[9:0];
        table_q[1] <= Tree1[9:0];
        table_q[2] <= Tree2[9:0];
        table_q[3] <= Tree3[9:0];
        table_q[4] <= Tree4[9:0];
        table_q[5] <= Tree5[9:0];
        table_q[6] <= Tree6[9:0];
        table_q[7] <= Tree7[9:0];
        root_l_q   <= Root_left;
        root_r_q   <= Root_right;
        node_q     <= '0;
        depth_q    <= '0;
        err_q      <= 1'b0;
        state_q    <= WALK;
      end else begin
        case (state_q)
          WALK: begin
            if (accept) begin
              // A new leaf overrides the clear above, keeping Sym_valid high.
              if (is_leaf) begin
                sym_q       <= next_node[3:0];
                len_q       <= depth_inc;
                sym_valid_q <= 1'b1;
                node_q      <= '0;
                depth_q     <= '0;
              end else if (is_internal && (depth_inc < 4'(MAX_DEPTH))) begin
                node_q  <= next_node;
                depth_q <= depth_inc;
              end else begin
                err_q   <= 1'b1;
                state_q <= ERR;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Sym_out   = sym_q;
  assign Code_len  = len_q;
  assign Sym_valid = sym_valid_q;
  assign Sym_cnt   = cnt_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: codeword table, directed corner sequences, and a
// randomized run checked against a prefix-code dictionary model.
module tb_huffman_decoder;

  logic        Clk_in = 1'b0;
  logic        n_Rst = 1'b0;
  logic        Load_tree = 1'b0;
  logic [14:0] tree [8];
  logic [4:0]  Root_left = '0, Root_right = '0;
  logic        Bit_in = 1'b0, Bit_valid = 1'b0, Sym_ready = 1'b0;
  logic        Bit_ready, Sym_valid, Err;
  logic [3:0]  Sym_out, Code_len;
  logic [15:0] Sym_cnt;

  int checks = 0;
  int failures = 0;

  huffman_decoder #(.MAX_DEPTH(9), .CNT_W(16)) dut (
    .Clk_in(Clk_in), .n_Rst(n_Rst), .Load_tree(Load_tree),
    .Tree0(tree[0]), .Tree1(tree[1]), .Tree2(tree[2]), .Tree3(tree[3]),
    .Tree4(tree[4]), .Tree5(tree[5]), .Tree6(tree[6]), .Tree7(tree[7]),
    .Root_left(Root_left), .Root_right(Root_right),
    .Bit_in(Bit_in), .Bit_valid(Bit_valid), .Bit_ready(Bit_ready),
    .Sym_out(Sym_out), .Code_len(Code_len), .Sym_valid(Sym_valid),
    .Sym_ready(Sym_ready), .Sym_cnt(Sym_cnt), .Err(Err)
  );

  always #5 Clk_in = ~Clk_in;

  typedef struct {
    logic [3:0]  code;
    int unsigned nbits;
    int unsigned sym;
    int unsigned len;
  } vec_t;
  vec_t vecs [10];

  // Leaf slot s of the reference tree has codeword code_val[s] (MSB first).
  int unsigned code_val [10] = '{4, 5, 6, 7, 4, 5, 6, 7, 0, 1};
  int unsigned code_len [10] = '{4, 4, 4, 4, 3, 3, 3, 3, 3, 3};
  int unsigned perm [10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input int unsigned p, input int unsigned l, input int unsigned r);
    return {5'(p), 5'(l), 5'(r)};
  endfunction

  task automatic build_tree();
    tree[0] = mk(10, perm[0], perm[1]);
    tree[1] = mk(11, perm[2], perm[3]);
    tree[2] = mk(12, perm[4], perm[5]);
    tree[3] = mk(13, perm[6], perm[7]);
    tree[4] = mk(14, perm[8], perm[9]);
    tree[5] = mk(15, 10, 11);
    tree[6] = mk(16, 12, 13);
    tree[7] = mk(17, 14, 15);
    Root_left  = 5'h11;
    Root_right = 5'h10;
  endtask

  task automatic identity_perm();
    for (int i = 0; i < 10; i++) perm[i] = i;
  endtask

  task automatic shuffle_perm();
    identity_perm();
    for (int i = 9; i > 0; i--) begin
      int j;
      int unsigned t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic step();
    @(posedge Clk_in); #1;
  endtask

  task automatic do_load();
    Load_tree = 1'b1;
    #1;
    chk("ready_during_load", int'(Bit_ready), 0);
    step();
    Load_tree = 1'b0;
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    Bit_in = b;
    Bit_valid = 1'b1;
    #1;
    while (!Bit_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      checks++;
      failures++;
      $display("FAIL bit_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    step();
    Bit_valid = 1'b0;
  endtask

  task automatic send_code(input logic [3:0] c, input int unsigned nb);
    for (int i = int'(nb) - 1; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic expect_sym(input string nm, input int unsigned s, input int unsigned l);
    chk({nm, "_valid"}, int'(Sym_valid), 1);
    chk({nm, "_sym"}, int'(Sym_out), int'(s));
    chk({nm, "_len"}, int'(Code_len), int'(l));
  endtask

  // Dictionary reference model state for the randomized run.
  logic        m_valid;
  int unsigned m_sym, m_len, m_cnt, buf_val, buf_len;
  logic        ld, exp_ready;

  initial begin
    for (int i = 0; i < 8; i++) tree[i] = '0;
    vecs = '{'{4'b0100, 4, 0, 4}, '{4'b0101, 4, 1, 4}, '{4'b0110, 4, 2, 4}, '{4'b0111, 4, 3, 4},
             '{4'b0100, 3, 4, 3}, '{4'b0101, 3, 5, 3}, '{4'b0110, 3, 6, 3}, '{4'b0111, 3, 7, 3},
             '{4'b0000, 3, 8, 3}, '{4'b0001, 3, 9, 3}};

    // Reset state
    step(); step();
    chk("rst_ready", int'(Bit_ready), 0);
    chk("rst_valid", int'(Sym_valid), 0);
    chk("rst_sym", int'(Sym_out), 0);
    chk("rst_len", int'(Code_len), 0);
    chk("rst_cnt", int'(Sym_cnt), 0);
    chk("rst_err", int'(Err), 0);
    n_Rst = 1'b1;
    Bit_valid = 1'b1;
    step(); step();
    chk("idle_ready", int'(Bit_ready), 0);
    Bit_valid = 1'b0;

    // Full-tree decode: 0100 000 100 111
    identity_perm();
    build_tree();
    Sym_ready = 1'b1;
    do_load();
    send_code(4'b0100, 4); expect_sym("full0", 0, 4);
    send_code(4'b0000, 3); expect_sym("full1", 8, 3);
    send_code(4'b0100, 3); expect_sym("full2", 4, 3);
    send_code(4'b0111, 3); expect_sym("full3", 7, 3);
    step();
    chk("full_valid_clear", int'(Sym_valid), 0);
    chk("full_cnt", int'(Sym_cnt), 4);

    // Every codeword of the reference tree
    foreach (vecs[k]) begin
      send_code(vecs[k].code, vecs[k].nbits);
      expect_sym($sformatf("vec%0d", k), vecs[k].sym, vecs[k].len);
    end
    step();
    chk("vec_cnt", int'(Sym_cnt), 14);

    // Backpressure
    Sym_ready = 1'b0;
    send_code(4'b0100, 4);
    expect_sym("bp_first", 0, 4);
    Bit_in = 1'b0;
    Bit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready", int'(Bit_ready), 0);
      chk("bp_hold_valid", int'(Sym_valid), 1);
      chk("bp_hold_sym", int'(Sym_out), 0);
      chk("bp_hold_len", int'(Code_len), 4);
    end
    Sym_ready = 1'b1;
    send_code(4'b0000, 3); expect_sym("bp1", 8, 3);
    send_code(4'b0100, 3); expect_sym("bp2", 4, 3);
    send_code(4'b0111, 3); expect_sym("bp3", 7, 3);
    step();
    chk("bp_cnt", int'(Sym_cnt), 18);

    // Invalid child
    tree[0] = mk(10, 5'h15, 1);
    Root_left = 5'h0a;
    do_load();
    send_bit(1'b0);
    chk("inv_err_early", int'(Err), 0);
    send_bit(1'b0);
    chk("inv_err", int'(Err), 1);
    chk("inv_ready", int'(Bit_ready), 0);
    chk("inv_valid", int'(Sym_valid), 0);
    build_tree();
    do_load();
    chk("inv_err_cleared", int'(Err), 0);
    send_code(4'b0000, 3); expect_sym("inv_resume", 8, 3);

    // Depth limit on a self-loop
    tree[0] = mk(10, 10, 1);
    Root_left = 5'h0a;
    do_load();
    for (int i = 0; i < 9; i++) begin
      send_bit(1'b0);
      chk("loop_no_sym", int'(Sym_valid), 0);
      chk("loop_err", int'(Err), (i == 8) ? 1 : 0);
    end

    // Reload mid-codeword
    build_tree();
    do_load();
    send_bit(1'b0);
    send_bit(1'b1);
    chk("reload_partial", int'(Sym_valid), 0);
    do_load();
    send_code(4'b0000, 3); expect_sym("reload", 8, 3);
    step();
    chk("reload_cnt", int'(Sym_cnt), 20);

    // Asynchronous reset with a symbol pending and a codeword in progress
    Sym_ready = 1'b0;
    send_code(4'b0000, 3);
    Bit_in = 1'b1;
    Bit_valid = 1'b1;
    #2 n_Rst = 1'b0;
    #1;
    chk("arst_valid", int'(Sym_valid), 0);
    chk("arst_sym", int'(Sym_out), 0);
    chk("arst_len", int'(Code_len), 0);
    chk("arst_cnt", int'(Sym_cnt), 0);
    chk("arst_err", int'(Err), 0);
    chk("arst_ready", int'(Bit_ready), 0);
    #3 n_Rst = 1'b1;
    step(); step(); step();
    chk("arst_idle_ready", int'(Bit_ready), 0);
    Bit_valid = 1'b0;

    // Randomized run against the dictionary model
    shuffle_perm();
    build_tree();
    do_load();
    m_valid = 1'b0; m_sym = 0; m_len = 0; m_cnt = 0; buf_val = 0; buf_len = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd_valid", int'(Sym_valid), int'(m_valid));
      if (m_valid) begin
        chk("rnd_sym", int'(Sym_out), int'(m_sym));
        chk("rnd_len", int'(Code_len), int'(m_len));
      end
      chk("rnd_cnt", int'(Sym_cnt), int'(m_cnt));
      chk("rnd_err", int'(Err), 0);
      Bit_valid = ($urandom_range(3, 0) != 0);
      Bit_in    = 1'($urandom_range(1, 0));
      Sym_ready = ($urandom_range(2, 0) != 0);
      ld        = ($urandom_range(63, 0) == 0);
      if (ld) begin
        shuffle_perm();
        build_tree();
      end
      Load_tree = ld;
      #1;
      exp_ready = !ld && (!m_valid || Sym_ready);
      chk("rnd_ready", int'(Bit_ready), int'(exp_ready));
      if (m_valid && Sym_ready) begin
        m_valid = 1'b0;
        m_cnt++;
      end
      if (ld) begin
        buf_val = 0;
        buf_len = 0;
      end else if (exp_ready && Bit_valid) begin
        buf_val = (buf_val << 1) | int'(Bit_in);
        buf_len++;
        for (int s = 0; s < 10; s++) begin
          if (code_len[s] == buf_len && code_val[s] == buf_val) begin
            m_valid = 1'b1;
            m_sym   = perm[s];
            m_len   = buf_len;
          end
        end
        if (m_valid && m_len == buf_len) begin
          buf_val = 0;
          buf_len = 0;
        end
      end
      @(posedge Clk_in); #1;
      Load_tree = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
